// File: rtl/rr_arb4_pkg.sv
// Shared types and helpers for the 4-channel round-robin select stage.
package rr_arb4_pkg;

  localparam int unsigned NCH = 4;

  typedef logic [1:0] sel_t;

  // Next channel index in round-robin order (3 wraps to 0).
  function automatic sel_t rr_next(input sel_t s);
    return s + sel_t'(1);
  endfunction

endpackage

// File: rtl/rr_arb4_stage_pick.sv
// Round-robin winner search: rotate the request vector so that ptr sits at
// bit 0, take the lowest set bit, then rotate the index back.
module rr_pick4
  import rr_arb4_pkg::*;
(
  input  logic [NCH-1:0] req,
  input  sel_t           ptr,
  output logic           found,
  output sel_t           g
);

  logic [2*NCH-1:0] dbl;
  logic [NCH-1:0]   rot;
  sel_t             idx;

  // Rotate, priority-encode lowest set bit, un-rotate.
  always_comb begin
    dbl   = {req, req};
    rot   = NCH'(dbl >> ptr);
    found = 1'b0;
    idx   = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        idx   = sel_t'(i);
      end
    end
    g = idx + ptr;
  end

endmodule

// File: rtl/rr_arb4_stage.sv
// 4-to-1 round-robin select stage with a one-entry output register.
// Optional burst locking is enabled with the RR_ARB4_LOCK_EN macro, which
// adds the req_last input port.
module rr_arb4_stage
  import rr_arb4_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NCH-1:0]            req_valid,
  input  logic [NCH-1:0][WIDTH-1:0] req_data,
`ifdef RR_ARB4_LOCK_EN
  input  logic [NCH-1:0]            req_last,
`endif
  output logic [NCH-1:0]            req_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output sel_t                      out_sel,
  input  logic                      out_ready
);

  sel_t           ptr;
  sel_t           g;
  logic           found;
  logic           can_load;
  logic           load;
  logic           last;
  logic [NCH-1:0] pick_req;

`ifdef RR_ARB4_LOCK_EN
  logic locked;
  sel_t lock_ch;

  // While a burst is open only the owning channel may compete.
  assign pick_req = locked ? (req_valid & (NCH'(1) << lock_ch)) : req_valid;
  assign last     = req_last[g];

  // Burst lock: open on a non-last grant, close on the last one.
  always_ff @(posedge clk) begin
    if (reset) begin
      locked  <= 1'b0;
      lock_ch <= '0;
    end else if (load) begin
      locked  <= ~last;
      lock_ch <= g;
    end
  end
`else
  assign pick_req = req_valid;
  assign last     = 1'b1;
`endif

  rr_pick4 u_pick (
    .req   (pick_req),
    .ptr   (ptr),
    .found (found),
    .g     (g)
  );

  assign can_load = ~out_valid | out_ready;
  assign load     = can_load & found & ~reset;

  // Grant is one-hot on the winner only when the buffer can take a word.
  always_comb begin
    req_ready = '0;
    if (load) req_ready[g] = 1'b1;
  end

  // Output buffer and fairness pointer; ptr moves only when a burst ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= req_data[g];
      out_sel   <= g;
      if (last) ptr <= rr_next(g);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
